pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 58 +++++
 tb/tb_pipeline_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: fetch/execute stage sequencer with halt, stall and a saturating retired-instruction counter.
module pipeline_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             stall,
  input  logic [4:0]       opcode,
  output logic             fe,
  output logic             e1,
  output logic             e2,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC1, EXEC2, HALT} state_t;
  state_t state, nxt;
  logic two_cyc, retire;
  // adm, sbm, ldr and lda need a second execute cycle
  assign two_cyc = opcode[4:1] == 4'b0001 || opcode[4:1] == 4'b0011 ||
                   opcode == 5'b01110 || opcode[4:2] == 3'b110;
  always_comb begin
    nxt = state;
    retire = 1'b0;
    if (!stall)
      case (state)
        IDLE, HALT: nxt = start ? FETCH : state;
        FETCH:      nxt = EXEC1;
        EXEC1: begin
          nxt = opcode == 5'b00000 ? HALT :
                two_cyc            ? EXEC2 :
                halt_req           ? HALT : FETCH;
          retire = !two_cyc;
        end
        EXEC2: begin
          nxt = halt_req ? HALT : FETCH;
          retire = 1'b1;
        end
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      retired <= '0;
    end else begin
      state <= nxt;
      retired <= retired + CNT_W'(retire && !(&retired));
    end
  end
  assign fe     = state == FETCH && !stall;
  assign e1     = state == EXEC1 && !stall;
  assign e2     = state == EXEC2 && !stall;
  assign halted = state == HALT;
  assign busy   = state == FETCH || state == EXEC1 || state == EXEC2;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed checks of sequencing, stall, halt, reset and counter saturation.
module tb_pipeline_sequencer;
  logic clk, n_reset, start, halt_req, stall;
  logic [4:0] opcode;
  logic fe, e1, e2, halted, busy;
  logic [15:0] retired;
  logic fe_s, e1_s, e2_s, halted_s, busy_s;
  logic [3:0] retired_s;
  int checks = 0;
  int failures = 0;

  pipeline_sequencer dut (
    .clk(clk), .n_reset(n_reset), .start(start), .halt_req(halt_req), .stall(stall),
    .opcode(opcode), .fe(fe), .e1(e1), .e2(e2), .halted(halted), .busy(busy), .retired(retired)
  );
  // narrow counter copy so saturation is reachable in a short run
  pipeline_sequencer #(.CNT_W(4)) dut_s (
    .clk(clk), .n_reset(n_reset), .start(start), .halt_req(halt_req), .stall(stall),
    .opcode(opcode), .fe(fe_s), .e1(e1_s), .e2(e2_s), .halted(halted_s), .busy(busy_s),
    .retired(retired_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b0; start = 1'b0; halt_req = 1'b0; stall = 1'b0; opcode = 5'b00100;
    #12;
    chk("rst_strobes", {fe, e1, e2, halted, busy}, 5'b00000);
    chk("rst_retired", retired, 16'd0);
    n_reset = 1'b1;
    step;
    chk("idle_hold", {fe, e1, e2, halted, busy}, 5'b00000);
    start = 1'b1;
    step;
    chk("start_fetch", {fe, e1, e2, busy}, 4'b1001);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      chk("adi_strobes", {fe, e1, e2}, (i % 2 == 0) ? 3'b010 : 3'b100);
    end
    chk("adi_retired", retired, 16'd3);
    chk("adi_retired_s", retired_s, 4'd3);
    opcode = 5'b11000;
    for (int i = 0; i < 6; i++) begin
      step;
      chk("lda_strobes", {fe, e1, e2}, (i % 3 == 0) ? 3'b010 : (i % 3 == 1) ? 3'b001 : 3'b100);
      chk("lda_retired", retired, (i < 2) ? 16'd3 : (i < 5) ? 16'd4 : 16'd5);
    end
    step;
    step;
    chk("e2_enter", {fe, e1, e2}, 3'b001);
    stall = 1'b1;
    #1;
    chk("stall_e2_off", {fe, e1, e2, busy}, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stall_hold", {fe, e1, e2, busy}, 4'b0001);
      chk("stall_retired", retired, 16'd5);
    end
    stall = 1'b0;
    #1;
    chk("stall_release_e2", {fe, e1, e2}, 3'b001);
    step;
    chk("after_stall_fetch", {fe, e1, e2}, 3'b100);
    chk("after_stall_retired", retired, 16'd6);
    opcode = 5'b00010;
    step;
    chk("adm_e1", {fe, e1, e2}, 3'b010);
    halt_req = 1'b1;
    step;
    chk("adm_e2_despite_halt", {fe, e1, e2, halted}, 4'b0010);
    chk("adm_e2_retired", retired, 16'd6);
    step;
    chk("adm_halt", {fe, e1, e2, halted, busy}, 5'b00010);
    chk("adm_halt_retired", retired, 16'd7);
    step;
    chk("halt_ignores_req", {halted, busy}, 2'b10);
    start = 1'b1;
    opcode = 5'b00100;
    step;
    chk("start_wins", {fe, halted}, 2'b10);
    start = 1'b0;
    step;
    chk("deferred_halt_e1", {fe, e1, e2}, 3'b010);
    step;
    chk("deferred_halt", {halted, busy}, 2'b10);
    chk("deferred_halt_retired", retired, 16'd8);
    halt_req = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    opcode = 5'b00000;
    step;
    chk("stp_e1", {fe, e1, e2}, 3'b010);
    step;
    chk("stp_halt", {fe, e1, e2, halted, busy}, 5'b00010);
    chk("stp_retired", retired, 16'd9);
    start = 1'b1;
    step;
    chk("stp_restart", {fe, halted, busy}, 3'b101);
    start = 1'b0;
    stall = 1'b1;
    opcode = 5'b00100;
    #1;
    chk("stall_fetch_off", {fe, e1, e2, busy}, 4'b0001);
    step;
    chk("stall_fetch_hold", {fe, e1, e2, busy}, 4'b0001);
    stall = 1'b0;
    #1;
    chk("stall_fetch_release", {fe, e1, e2}, 3'b100);
    for (int i = 0; i < 40; i++) step;
    chk("long_run_retired", retired, 16'd29);
    chk("saturated_s", retired_s, 4'hF);
    step;
    chk("mid_e1", {fe, e1, e2}, 3'b010);
    chk("mid_e1_retired", retired, 16'd29);
    #2;
    n_reset = 1'b0;
    #1;
    chk("async_rst_strobes", {fe, e1, e2, halted, busy}, 5'b00000);
    chk("async_rst_retired", retired, 16'd0);
    chk("async_rst_retired_s", retired_s, 4'd0);
    start = 1'b1;
    step;
    chk("rst_held_idle", {fe, busy, retired[0]}, 3'b000);
    #3;
    n_reset = 1'b1;
    #1;
    chk("release_no_move", {fe, busy}, 2'b00);
    step;
    chk("release_first_edge", {fe, busy}, 2'b11);
    start = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
